// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serialises one NB_DATA-bit word per request into an asynchronous frame:
//   start bit (0), NB_DATA data bits LSB first, optional parity bit, and
//   NB_STOP stop bits (1). Each bit lasts DIV = CLK_FREQ / BAUD_RATE clocks.
//
// Ports
//   clk         system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_tx_start  send request, level-sampled every clock
//   i_tx_data   word to send, captured only when a request is accepted
//   o_tx        serial line, registered, idles high
//   o_tx_busy   high while a frame is on the line
//   o_tx_done   one-clock pulse when the last stop bit completes
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | line high, waiting for i_tx_start
// START  | driving the start bit (0)
// DATA   | driving data bit idx_q (LSB first, from the shift register)
// PARITY | driving the parity bit (only when parity is enabled)
// STOP   | driving NB_STOP stop bits as one NB_STOP*DIV interval
module uart_tx_framer #(
  parameter int         NB_DATA     = 8,
  parameter int         CLK_FREQ    = 100000000,
  parameter int         BAUD_RATE   = 115200,
  parameter logic [1:0] F_TX_PARITY = 2'b00,
  parameter int         NB_STOP     = 1
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int DIV      = CLK_FREQ / BAUD_RATE;
  localparam int STOP_LEN = NB_STOP * DIV;
  // The stop interval is the longest one the counter has to time.
  localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int IDX_W    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_DATA - 1);

  // Mode 2'b11 is deliberately treated as "no parity".
  localparam logic PAR_EN  = (F_TX_PARITY == 2'b01) || (F_TX_PARITY == 2'b10);
  localparam logic PAR_ODD = (F_TX_PARITY == 2'b10);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic bit_end;
  logic stop_end;
  logic accept;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign stop_end = (cnt_q == STOP_LAST);

  // A request is also taken on the very edge the last stop bit ends, so a
  // held i_tx_start yields frames with no idle gap between them.
  assign accept = i_tx_start &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_end));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Parity is computed from the word at capture time, since the shift
    // register is consumed as the bits go out.
    if (accept) begin
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
      shreg_d = i_tx_data;
      par_d   = (^i_tx_data) ^ PAR_ODD;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. Four instances cover the parity / stop-bit
// variants (DIV = 16). The stimulus side decides which requests are accepted
// from frame timing alone and queues the expected frame; the monitor pops a
// frame when the selected instance goes busy and compares the line, busy and
// done every clock against a waveform built from the framing rules.
module tb_uart_tx_framer;

  localparam int DIV = 16;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    longint     edge_no;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       start_v = 1'b0;
  logic [7:0] data_v = 8'h00;
  logic [3:0] start_w;
  logic [3:0] tx_w, busy_w, done_w;
  logic       tx_m, busy_m, done_m;

  longint cyc = 0;
  longint free_at = 0;
  int     n_acc = 0;
  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  longint start_seen[$];
  longint done_seen[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_w = start_v ? (4'b0001 << sel) : 4'b0000;
  always_comb begin
    tx_m   = tx_w[sel];
    busy_m = busy_w[sel];
    done_m = done_w[sel];
  end

  uart_tx_framer #(.NB_DATA(8), .CLK_FREQ(16), .BAUD_RATE(1), .F_TX_PARITY(2'b00), .NB_STOP(1)) u_none1 (
    .clk(clk), .i_rst(rst), .i_tx_start(start_w[0]), .i_tx_data(data_v),
    .o_tx(tx_w[0]), .o_tx_busy(busy_w[0]), .o_tx_done(done_w[0]));
  uart_tx_framer #(.NB_DATA(8), .CLK_FREQ(16), .BAUD_RATE(1), .F_TX_PARITY(2'b01), .NB_STOP(1)) u_even1 (
    .clk(clk), .i_rst(rst), .i_tx_start(start_w[1]), .i_tx_data(data_v),
    .o_tx(tx_w[1]), .o_tx_busy(busy_w[1]), .o_tx_done(done_w[1]));
  uart_tx_framer #(.NB_DATA(8), .CLK_FREQ(16), .BAUD_RATE(1), .F_TX_PARITY(2'b10), .NB_STOP(1)) u_odd1 (
    .clk(clk), .i_rst(rst), .i_tx_start(start_w[2]), .i_tx_data(data_v),
    .o_tx(tx_w[2]), .o_tx_busy(busy_w[2]), .o_tx_done(done_w[2]));
  uart_tx_framer #(.NB_DATA(8), .CLK_FREQ(16), .BAUD_RATE(1), .F_TX_PARITY(2'b00), .NB_STOP(2)) u_none2 (
    .clk(clk), .i_rst(rst), .i_tx_start(start_w[3]), .i_tx_data(data_v),
    .o_tx(tx_w[3]), .o_tx_busy(busy_w[3]), .o_tx_done(done_w[3]));

  // 0 none, 1 even, 2 odd
  function automatic int par_mode(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
  endfunction

  function automatic int n_stop(input logic [1:0] s);
    return (s == 2'd3) ? 2 : 1;
  endfunction

  function automatic longint frame_cycles(input logic [1:0] s);
    return longint'((1 + 8 + ((par_mode(s) != 0) ? 1 : 0) + n_stop(s)) * DIV);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus, applied at the falling edge for the next rising edge.
  task automatic drive(input logic st, input logic [7:0] d);
    frame_t f;
    @(negedge clk);
    start_v = st;
    data_v  = d;
    if (st && !rst && (cyc + 1 >= free_at)) begin
      f.data    = d;
      f.sel     = sel;
      f.edge_no = cyc + 1;
      exp_q.push_back(f);
      free_at = cyc + 1 + frame_cycles(sel);
      n_acc++;
    end
  endtask

  task automatic wait_idle();
    while (cyc < free_at + 2) drive(1'b0, 8'($urandom));
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    frame_t f;
    logic   wave[$];
    int     pos;
    bit     in_frame;
    logic   e_tx, e_busy, e_done, p;
    pos = 0;
    in_frame = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        wave.delete();
        check("rst_tx", tx_m, 1);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        continue;
      end
      e_done = 1'b0;
      if (in_frame && pos == wave.size()) begin
        e_done = 1'b1;
        in_frame = 0;
        done_seen.push_back(cyc);
      end
      if (!in_frame && busy_m) begin
        check("frame_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("accept_edge", cyc, f.edge_no);
          start_seen.push_back(cyc);
          wave.delete();
          for (int i = 0; i < DIV; i++) wave.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int i = 0; i < DIV; i++) wave.push_back(f.data[b]);
          if (par_mode(f.sel) != 0) begin
            p = ^f.data;
            if (par_mode(f.sel) == 2) p = ~p;
            for (int i = 0; i < DIV; i++) wave.push_back(p);
          end
          for (int i = 0; i < n_stop(f.sel) * DIV; i++) wave.push_back(1'b1);
          pos = 0;
          in_frame = 1;
        end
      end
      e_tx   = in_frame ? wave[pos] : 1'b1;
      e_busy = in_frame;
      check("line", tx_m, e_tx);
      check("busy", busy_m, e_busy);
      check("done", done_m, e_done);
      if (in_frame) pos++;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    longint e;
    int     a0;
    int     budget;

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("por_tx", tx_w[k], 1);
      check("por_busy", busy_w[k], 0);
      check("por_done", done_w[k], 0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) drive(1'b0, 8'h00);

    // 0x55, no parity, one stop bit.
    sel = 2'd0;
    drive(1'b1, 8'h55);
    drive(1'b0, 8'hFF);
    wait_idle();
    check("frame55_done_latency", done_seen[$] - start_seen[$], 160);

    // Parity variants.
    sel = 2'd1;
    drive(1'b1, 8'h07); drive(1'b0, 8'h00); wait_idle();
    check("even07_done_latency", done_seen[$] - start_seen[$], 176);
    drive(1'b1, 8'h00); drive(1'b0, 8'hFF); wait_idle();
    sel = 2'd2;
    drive(1'b1, 8'h07); drive(1'b0, 8'h00); wait_idle();
    check("odd07_done_latency", done_seen[$] - start_seen[$], 176);

    // Request while busy is dropped; data changes mid-frame are ignored.
    sel = 2'd0;
    a0 = done_seen.size();
    drive(1'b1, 8'h3C);
    e = cyc + 1;
    while (cyc + 1 < e + 40) drive(1'b0, 8'($urandom));
    drive(1'b1, 8'hA3);
    drive(1'b0, 8'h5A);
    wait_idle();
    check("busy_single_done", done_seen.size() - a0, 1);

    // Reset in the middle of a frame (0xC6 has bit 3 low, so the line is low at clock 70).
    drive(1'b1, 8'hC6);
    e = cyc + 1;
    while (cyc < e + 70) drive(1'b0, 8'($urandom));
    a0 = done_seen.size();
    #1 rst = 1'b1;
    #1;
    check("midrst_tx", tx_m, 1);
    check("midrst_busy", busy_m, 0);
    check("midrst_done", done_m, 0);
    free_at = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h81);
    drive(1'b0, 8'h00);
    wait_idle();
    check("midrst_done_count", done_seen.size() - a0, 1);

    // Back-to-back with start held high, two stop bits.
    sel = 2'd3;
    a0 = n_acc;
    budget = 1000;
    while (n_acc < a0 + 2 && budget > 0) begin
      drive(1'b1, (n_acc == a0) ? 8'h0F : 8'hF0);
      budget--;
    end
    check("b2b_accepts_in_budget", longint'(budget > 0), 1);
    drive(1'b0, 8'h00);
    wait_idle();
    check("b2b_start_gap", start_seen[$] - start_seen[start_seen.size() - 2], 176);
    check("b2b_done_gap", done_seen[$] - done_seen[done_seen.size() - 2], 176);

    // Randomised traffic on every variant.
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      repeat (400) drive(($urandom_range(0, 7) == 0), 8'($urandom));
      drive(1'b0, 8'h00);
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame.
REQ-002 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-004 Parameter F_TX_PARITY, default 2'b00, parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-005 Parameter NB_STOP, default 1, stop bits per frame; legal values are 1 or 2.
REQ-006 Port clk, input, 1, single system clock; all logic on the rising edge.
REQ-007 Port i_rst, input, 1, reset, asynchronous and active-high.
REQ-008 Port i_tx_start, input, 1, request to send i_tx_data; level-sampled each clock.
REQ-009 Port i_tx_data, input, NB_DATA, byte to transmit (e.g. ALU result); sampled only on acceptance.
REQ-010 Port o_tx, output, 1, serial line, registered, idle high.
REQ-011 Port o_tx_busy, output, 1, high while a frame is in progress.
REQ-012 Port o_tx_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-013 Bit period shall be DIV = CLK_FREQ / BAUD_RATE clocks, using integer truncation (868 at defaults); each bit shall last exactly DIV clocks.
REQ-014 The FSM shall have states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE, i_tx_start=1 at edge E0 shall accept the request, latch i_tx_data into a shift register, and enter START.
REQ-016 START shall drive o_tx=0 from E0 for DIV clocks, then enter DATA.
REQ-017 DATA shall send NB_DATA bits LSB first; bit k shall drive o_tx from edge E0+(1+k)*DIV.
REQ-018 After the last data bit, the FSM shall enter PARITY if parity is enabled, otherwise STOP.
REQ-019 PARITY shall drive the XOR of the latched bits (even mode) or its inverse (odd mode) for DIV clocks.
REQ-020 STOP shall drive o_tx=1 for NB_STOP*DIV clocks, then return to IDLE.
REQ-021 Frame length shall be N = 1 + NB_DATA + P + NB_STOP bits, where P is 1 if parity is enabled and 0 otherwise.
REQ-022 o_tx_busy shall be 1 from edge E0 through edge E0+N*DIV, exclusive; it shall be 0 otherwise.
REQ-023 o_tx_done shall be 1 for exactly one clock, beginning at edge E0+N*DIV, coincident with the return to IDLE.
REQ-024 i_tx_start while busy shall be ignored, with no queueing and no effect on the current frame.
REQ-025 Changes on i_tx_data after acceptance shall not affect the frame in flight.
REQ-026 i_tx_start=1 in the cycle o_tx_done is high shall be accepted, giving back-to-back frames with no extra idle bit.
REQ-027 i_tx_start held high continuously shall send frames back-to-back, re-sampling i_tx_data at each acceptance.
REQ-028 The bit-period counter shall reset to 0 on each state transition and shall never wrap mid-bit.
REQ-029 The data-bit index counter shall be sized to count 0..NB_DATA-1 and shall reset to 0 at START entry.

Reset
REQ-030 i_rst=1 shall immediately, without waiting for clk, force: state IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, all counters 0, shift register 0.
REQ-031 Reset mid-frame shall abort the frame, with no o_tx_done pulse.
REQ-032 After i_rst falls, the first clock with i_tx_start=1 shall be accepted normally.

Verification (sim parameters CLK_FREQ=16, BAUD_RATE=1, so DIV=16)
REQ-033 Reset check: assert i_rst with no clock edge -> o_tx=1, o_tx_busy=0, o_tx_done=0.
REQ-034 Send 0x55, no parity, NB_STOP=1 -> o_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 clocks; o_tx_done pulses exactly 160 clocks after E0.
REQ-035 Parity: 0x07 with even parity gives parity bit 1; 0x07 with odd parity gives parity bit 0; 0x00 with even parity gives parity bit 0; N=11, so o_tx_done fires at 176 clocks.
REQ-036 Busy handling: pulse i_tx_start with 0xA3 at clock 40 of a 0x3C frame, and change i_tx_data mid-frame -> only 0x3C is sent, with a single o_tx_done.
REQ-037 Reset mid-frame: assert i_rst at clock 70 of a frame -> o_tx=1 at once, no o_tx_done; a following send of 0x81 is serialized correctly.
REQ-038 Back-to-back: hold i_tx_start high and send 0x0F then 0xF0 with NB_STOP=2 -> second start bit falls at clock 176; two o_tx_done pulses, 176 clocks apart.
